// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder sequencing controller.
package serial_add_pkg;

   localparam int SADD_WIDTH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      DRAIN,
      DONE
   } state_t;

   // Bits needed to hold values 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_add_shreg.sv
// WIDTH-bit parallel-load, shift-right register feeding one adder operand LSB-first.
module serial_add_shreg
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SADD_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             lsb
);

   logic [WIDTH-1:0] q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {1'b0, q[WIDTH-1:1]};
      end
   end

   assign lsb = q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for an external Moore serial adder: load operands, clear, stream bits, collect result.
// Optional build macro: SERIAL_ADD_CTRL_STATS_EN adds the op_count handshake counter.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SADD_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             add_rst,
   output logic             add_a_bit,
   output logic             add_b_bit,
   input  logic             add_sum,
   input  logic             add_carry
`ifdef SERIAL_ADD_CTRL_STATS_EN
   ,
   output logic [15:0]      op_count
`endif
);

   localparam int CW = clog2(WIDTH);
   localparam int IW = clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t          state;
   state_t          state_d;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   bit_idx;
   logic [WIDTH:0]  res;
   logic            add_rst_q;
   logic            load;
   logic            shift;
   logic            sa_lsb;
   logic            sb_lsb;

   serial_add_shreg #(.WIDTH(WIDTH)) u_shreg_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .d     (in_a),
      .lsb   (sa_lsb)
   );

   serial_add_shreg #(.WIDTH(WIDTH)) u_shreg_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .d     (in_b),
      .lsb   (sb_lsb)
   );

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_a_bit = 1'b0;
      add_b_bit = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = CLEAR;
            end
         end
         CLEAR: state_d = SHIFT;
         SHIFT: begin
            add_a_bit = sa_lsb;
            add_b_bit = sb_lsb;
            shift     = 1'b1;
            if (cnt == CNT_LAST) state_d = DRAIN;
         end
         DRAIN: state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The adder output lags its inputs by one cycle, so SHIFT cycle cnt holds sum bit cnt-1.
   assign bit_idx = IW'(cnt) - IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         res       <= '0;
         add_rst_q <= 1'b1;
      end else begin
         state     <= state_d;
         add_rst_q <= (state_d == CLEAR);
         case (state)
            IDLE: begin
               cnt <= '0;
               if (load) res <= '0;
            end
            CLEAR: cnt <= '0;
            SHIFT: begin
               if (cnt != '0) res[bit_idx] <= add_sum;
               cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            end
            DRAIN: begin
               res[WIDTH-1] <= add_sum;
               res[WIDTH]   <= add_carry;
            end
            default: ;
         endcase
      end
   end

   assign add_rst = add_rst_q;
   assign out_sum = res;

`ifdef SERIAL_ADD_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural Moore serial adder attached.
module tb_serial_add_ctrl;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          add_sum = 1'b0;
   logic          add_carry = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [W:0]    out_sum;
   logic          add_rst;
   logic          add_a_bit;
   logic          add_b_bit;
`ifdef SERIAL_ADD_CTRL_STATS_EN
   logic [15:0]   op_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .add_rst   (add_rst),
      .add_a_bit (add_a_bit),
      .add_b_bit (add_b_bit),
      .add_sum   (add_sum),
      .add_carry (add_carry)
`ifdef SERIAL_ADD_CTRL_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   always #5 clk = ~clk;

   // Moore serial adder: registered sum/carry, synchronous active-high clear.
   always @(posedge clk) begin
      if (add_rst) {add_carry, add_sum} <= 2'b00;
      else         {add_carry, add_sum} <= 2'(add_a_bit) + 2'(add_b_bit) + 2'(add_carry);
   end

   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one operation from IDLE, returns the result and cycles from acceptance to out_valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] res, output int lat);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      res = out_sum;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
      n_tests++; if (add_rst !== 1'b1) begin n_fail++; $display("FAIL reset_add_rst: got %b want 1", add_rst); end
      n_tests++; if ({add_a_bit, add_b_bit} !== 2'b00) begin n_fail++; $display("FAIL reset_bits: got %b want 00", {add_a_bit, add_b_bit}); end
      rst_n = 1'b1;
      tick();
      n_tests++; if (add_rst !== 1'b0) begin n_fail++; $display("FAIL release_add_rst: got %b want 0", add_rst); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = 4'hB; b = 4'hD;
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      n_tests++; if (add_rst !== 1'b1) begin n_fail++; $display("FAIL basic_clear: add_rst got %b want 1", add_rst); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy: in_ready got %b want 0", in_ready); end
      for (int k = 0; k < W; k++) begin
         tick();
         n_tests++;
         if ({add_a_bit, add_b_bit} !== {a[k], b[k]}) begin
            n_fail++; $display("FAIL basic_bits[%0d]: got %b want %b", k, {add_a_bit, add_b_bit}, {a[k], b[k]});
         end
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d]: got %b want 0", k, out_valid); end
      end
      tick();
      n_tests++; if ({add_a_bit, add_b_bit} !== 2'b00) begin n_fail++; $display("FAIL basic_drain_bits: got %b want 00", {add_a_bit, add_b_bit}); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
      tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: out_valid got %b want 1 after %0d cycles", out_valid, W + 2); end
      n_tests++; if (out_sum !== ref_sum(a, b)) begin n_fail++; $display("FAIL basic_sum: got %h want %h", out_sum, ref_sum(a, b)); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return_idle: in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] ta [3] = '{4'hF, 4'h0, 4'hF};
      logic [W-1:0] tb [3] = '{4'hF, 4'h0, 4'h1};
      logic [W:0]   res;
      int           lat;
      for (int i = 0; i < 3; i++) begin
         run_op(ta[i], tb[i], res, lat);
         n_tests++; if (res !== ref_sum(ta[i], tb[i])) begin n_fail++; $display("FAIL boundary_sum[%0d]: got %h want %h", i, res, ref_sum(ta[i], tb[i])); end
         n_tests++; if (lat != W + 2) begin n_fail++; $display("FAIL boundary_latency[%0d]: got %0d want %0d", i, lat, W + 2); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   res;
      int           lat;
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         run_op(a, b, res, lat);
         n_tests++; if (res !== ref_sum(a, b)) begin n_fail++; $display("FAIL random_sum[%0d] %h+%h: got %h want %h", i, a, b, res, ref_sum(a, b)); end
         n_tests++; if (lat != W + 2) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, W + 2); end
      end
   endtask

   task automatic test_backpressure();
      logic [W:0] expect_sum;
      int         guard;
      expect_sum = ref_sum(4'h9, 4'h8);
      in_a = 4'h9; in_b = 4'h8; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 40) begin tick(); guard++; end
      in_a = 4'h1; in_b = 4'h2; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
         n_tests++; if (out_sum !== expect_sum) begin n_fail++; $display("FAIL bp_sum[%0d]: got %h want %h", i, out_sum, expect_sum); end
         n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_tests++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: in_ready,out_valid got %b want 10", {in_ready, out_valid}); end
      tick();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_second_op: in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      localparam int N = 4;
      logic [W-1:0] opa [N];
      logic [W-1:0] opb [N];
      logic [W:0]   exp_q [$];
      logic [W:0]   want;
      int           acc_cnt, res_cnt, last_acc, cyc;
      bit           accept_now;
      opa[0] = 4'hF; opb[0] = 4'hF;
      opa[1] = 4'h0; opb[1] = 4'h0;
      opa[2] = 4'h1; opb[2] = 4'h0;
      opa[3] = W'($urandom); opb[3] = W'($urandom);
      acc_cnt = 0; res_cnt = 0; last_acc = 0; cyc = 0;
      in_a = opa[0]; in_b = opb[0]; in_valid = 1'b1; out_ready = 1'b1;
      while (res_cnt < N && cyc < 200) begin
         if (out_valid) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_tests++; if (out_sum !== want) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %h want %h", res_cnt, out_sum, want); end
            res_cnt++;
         end
         accept_now = in_ready && in_valid;
         tick();
         cyc++;
         if (accept_now) begin
            if (acc_cnt > 0) begin
               n_tests++; if (cyc - last_acc != W + 4) begin n_fail++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", acc_cnt, cyc - last_acc, W + 4); end
            end
            last_acc = cyc;
            exp_q.push_back(ref_sum(opa[acc_cnt], opb[acc_cnt]));
            acc_cnt++;
            if (acc_cnt < N) begin in_a = opa[acc_cnt]; in_b = opb[acc_cnt]; end
            else in_valid = 1'b0;
         end
      end
      n_tests++; if (res_cnt != N) begin n_fail++; $display("FAIL b2b_timeout: results got %0d want %0d", res_cnt, N); end
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_shift();
      logic [W:0] res;
      int         lat;
      in_a = 4'hF; in_b = 4'hF; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (add_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_add_rst: got %b want 1", add_rst); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      n_tests++; if (out_sum !== '0) begin n_fail++; $display("FAIL midrst_out_sum: got %h want 0", out_sum); end
      tick();
      rst_n = 1'b1;
      run_op(4'h3, 4'h5, res, lat);
      n_tests++; if (res !== 5'h08) begin n_fail++; $display("FAIL midrst_followup_sum: got %h want 08", res); end
      n_tests++; if (lat != W + 2) begin n_fail++; $display("FAIL midrst_followup_latency: got %0d want %0d", lat, W + 2); end
   endtask

`ifdef SERIAL_ADD_CTRL_STATS_EN
   task automatic test_stats();
      logic [W:0] res;
      int         lat;
      rst_n = 1'b0;
      #2;
      n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d want 0", op_count); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) run_op(W'($urandom), W'($urandom), res, lat);
      n_tests++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL stats_count: got %0d want 3", op_count); end
      in_a = 4'h2; in_b = 4'h2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < W + 5; i++) tick();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stats_pending_valid: got %b want 1", out_valid); end
      n_tests++; if (op_count !== 16'd3) begin n_fail++; $display("FAIL stats_unaccepted: got %0d want 3", op_count); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_shift();
`ifdef SERIAL_ADD_CTRL_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
